// File: rtl/mem_rd_burst_arbiter_if.sv
// mem_rd_burst_arbiter_if
//   Bundles the two burst command channels, the memory read port, the
//   AXI-Stream output and the busy flag of mem_rd_burst_arbiter.
//   master : the arbiter side (drives ready, read strobe/address, stream, busy)
//   slave  : the environment side (requesters, memory, stream sink)
interface mem_rd_burst_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic                    req0_valid;
    logic                    req0_ready;
    logic [ADDR_WIDTH-1:0]   req0_base;
    logic [LEN_WIDTH-1:0]    req0_len;
    logic                    req1_valid;
    logic                    req1_ready;
    logic [ADDR_WIDTH-1:0]   req1_base;
    logic [LEN_WIDTH-1:0]    req1_len;
    logic                    mem_rd_en;
    logic [ADDR_WIDTH-1:0]   mem_rd_addr;
    logic [DATA_WIDTH-1:0]   mem_rd_data;
    logic [DATA_WIDTH-1:0]   m_axis_tdata;
    logic [DATA_WIDTH/8-1:0] m_axis_tstrb;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic                    m_axis_tlast;
    logic                    m_axis_tdest;
    logic                    busy;

    modport master (
        input  req0_valid, req0_base, req0_len,
        input  req1_valid, req1_base, req1_len,
        input  mem_rd_data, m_axis_tready,
        output req0_ready, req1_ready, mem_rd_en, mem_rd_addr,
        output m_axis_tdata, m_axis_tstrb, m_axis_tvalid, m_axis_tlast, m_axis_tdest,
        output busy
    );

    modport slave (
        output req0_valid, req0_base, req0_len,
        output req1_valid, req1_base, req1_len,
        output mem_rd_data, m_axis_tready,
        input  req0_ready, req1_ready, mem_rd_en, mem_rd_addr,
        input  m_axis_tdata, m_axis_tstrb, m_axis_tvalid, m_axis_tlast, m_axis_tdest,
        input  busy
    );
endinterface

// File: rtl/mem_rd_burst_arbiter.sv
// mem_rd_burst_arbiter
//   Shares a 1-cycle-latency memory read port between two burst requesters.
//   Commands are granted round-robin, one whole burst at a time; read data
//   is returned on an AXI-Stream master tagged with the channel (tdest) and
//   delimited by tlast. A small output FIFO absorbs stream backpressure and
//   reads are only issued when the FIFO has room for them (credit rule).
// Ports
//   s01_axis_aclk    clock, rising edge
//   s01_axis_areset  synchronous active-high reset
//   bus              mem_rd_burst_arbiter_if.master: command channels,
//                    memory read port, AXI-Stream output, busy
module mem_rd_burst_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   s01_axis_aclk,
    input  logic                   s01_axis_areset,
    mem_rd_burst_arbiter_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic                  chan;
    } entry_t;

    state_t                state;
    logic                  last_grant;
    logic                  chan_q;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat;

    // Tag travelling alongside the read in flight
    logic                  rd_vld;
    logic                  rd_last;
    logic                  rd_chan;

    entry_t                fifo [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic                  grant_ch;
    logic                  accept;
    logic                  issue;
    logic                  issue_last;
    logic                  push;
    logic                  pop;
    logic                  tvalid;
    logic [CW:0]           occ;
    entry_t                head;

    always_comb begin
        // Tie goes to the channel that did not win last time
        grant_ch   = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
        accept     = !s01_axis_areset && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
        // FIFO entries plus the read whose data is still on its way
        occ        = {1'b0, count} + {{CW{1'b0}}, rd_vld};
        issue      = !s01_axis_areset && (state == BURST) && (occ < DEPTH_C);
        issue_last = (beat == len_q);
        tvalid     = (count != '0);
        head       = fifo[rd_ptr];
        push       = rd_vld;
        pop        = tvalid && bus.m_axis_tready;
    end

    assign bus.req0_ready    = accept && !grant_ch;
    assign bus.req1_ready    = accept && grant_ch;
    assign bus.mem_rd_en     = issue;
    assign bus.mem_rd_addr   = issue ? cur_addr : '0;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tdata  = tvalid ? head.data : '0;
    assign bus.m_axis_tlast  = tvalid && head.last;
    assign bus.m_axis_tdest  = tvalid && head.chan;
    assign bus.m_axis_tstrb  = tvalid ? '1 : '0;
    assign bus.busy          = (state != IDLE);

    always_ff @(posedge s01_axis_aclk) begin
        if (s01_axis_areset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            chan_q     <= 1'b0;
            cur_addr   <= '0;
            len_q      <= '0;
            beat       <= '0;
            rd_vld     <= 1'b0;
            rd_last    <= 1'b0;
            rd_chan    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            rd_vld  <= issue;
            rd_last <= issue_last;
            rd_chan <= chan_q;

            if (push) begin
                fifo[wr_ptr] <= {bus.mem_rd_data, rd_last, rd_chan};
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: if (accept) begin
                    cur_addr   <= grant_ch ? bus.req1_base : bus.req0_base;
                    len_q      <= grant_ch ? bus.req1_len  : bus.req0_len;
                    chan_q     <= grant_ch;
                    last_grant <= grant_ch;
                    beat       <= '0;
                    state      <= BURST;
                end
                BURST: if (issue) begin
                    cur_addr <= cur_addr + ADDR_WIDTH'(1);
                    beat     <= beat + LEN_WIDTH'(1);
                    if (issue_last)
                        state <= DRAIN;
                end
                DRAIN: if (pop && head.last)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_rd_burst_arbiter.sv
module tb_mem_rd_burst_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          dest;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_rd_burst_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    mem_rd_burst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(4)) dut (
        .s01_axis_aclk  (clk),
        .s01_axis_areset(rst),
        .bus            (bus)
    );

    int checks = 0;
    int errors = 0;

    // Memory contents: unique, address-derived word
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return {a, 4'hA, ~a, 4'h5};
    endfunction

    always @(posedge clk)
        if (bus.mem_rd_en) bus.mem_rd_data <= mem_val(bus.mem_rd_addr);

    // Reference model: expected beats and read addresses, per accepted command
    beat_t         exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic          model_last;
    int            outstanding;
    int            pops = 0;
    int            issues = 0;
    logic          hold_v = 1'b0;
    logic [DW-1:0] h_data;
    logic          h_last, h_dest;

    function automatic void add_burst(input logic ch, input logic [AW-1:0] base, input logic [LW-1:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            logic [AW-1:0] a;
            beat_t b;
            a = base + AW'(i);
            addr_q.push_back(a);
            b.data = mem_val(a);
            b.last = (i == int'(len));
            b.dest = ch;
            exp_q.push_back(b);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            addr_q.delete();
            outstanding = 0;
            model_last  = 1'b1;
            hold_v      = 1'b0;
        end else begin
            if (hold_v) begin
                checks++;
                if (!bus.m_axis_tvalid || bus.m_axis_tdata !== h_data ||
                    bus.m_axis_tlast !== h_last || bus.m_axis_tdest !== h_dest) begin
                    errors++;
                    $display("FAIL axis_hold got v=%b d=%h l=%b t=%b exp v=1 d=%h l=%b t=%b",
                             bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tdest,
                             h_data, h_last, h_dest);
                end
            end
            if (bus.m_axis_tvalid) begin
                checks++;
                if (bus.m_axis_tstrb !== 4'hF) begin
                    errors++;
                    $display("FAIL tstrb got %h exp f", bus.m_axis_tstrb);
                end
            end
            if (!bus.busy && (bus.req0_valid || bus.req1_valid)) begin
                logic exp_ch;
                exp_ch = (bus.req0_valid && bus.req1_valid) ? ~model_last : bus.req1_valid;
                checks++;
                if ({bus.req1_ready, bus.req0_ready} !== (exp_ch ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL grant got ready=%b%b exp ch%0d", bus.req1_ready, bus.req0_ready, exp_ch);
                end
            end else if (bus.req0_ready || bus.req1_ready) begin
                checks++;
                errors++;
                $display("FAIL ready_not_idle got ready=%b%b busy=%b exp 00",
                         bus.req1_ready, bus.req0_ready, bus.busy);
            end
            if (bus.req0_valid && bus.req0_ready) begin
                add_burst(1'b0, bus.req0_base, bus.req0_len);
                model_last = 1'b0;
            end else if (bus.req1_valid && bus.req1_ready) begin
                add_burst(1'b1, bus.req1_base, bus.req1_len);
                model_last = 1'b1;
            end
            if (bus.mem_rd_en) begin
                checks++;
                if (outstanding >= 4) begin
                    errors++;
                    $display("FAIL credit got outstanding=%0d exp <4 at issue", outstanding);
                end
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_addr got %h exp no read", bus.mem_rd_addr);
                end else begin
                    if (bus.mem_rd_addr !== addr_q[0]) begin
                        errors++;
                        $display("FAIL rd_addr got %h exp %h", bus.mem_rd_addr, addr_q[0]);
                    end
                    void'(addr_q.pop_front());
                end
                outstanding++;
                issues++;
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat got d=%h exp no beat", bus.m_axis_tdata);
                end else begin
                    if (bus.m_axis_tdata !== exp_q[0].data || bus.m_axis_tlast !== exp_q[0].last ||
                        bus.m_axis_tdest !== exp_q[0].dest) begin
                        errors++;
                        $display("FAIL beat got d=%h l=%b t=%b exp d=%h l=%b t=%b",
                                 bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tdest,
                                 exp_q[0].data, exp_q[0].last, exp_q[0].dest);
                    end
                    void'(exp_q.pop_front());
                end
                outstanding--;
                pops++;
            end
            hold_v = bus.m_axis_tvalid && !bus.m_axis_tready;
            h_data = bus.m_axis_tdata;
            h_last = bus.m_axis_tlast;
            h_dest = bus.m_axis_tdest;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk); #1;
            done = !bus.busy && !bus.m_axis_tvalid && exp_q.size() == 0;
            @(posedge clk); #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout got busy=%b pending=%0d exp idle/0", name, bus.busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus.m_axis_tvalid, bus.busy, bus.mem_rd_en, bus.req0_ready, bus.req1_ready,
             bus.m_axis_tlast, bus.m_axis_tdest} !== 7'b0 || bus.m_axis_tdata !== '0 ||
            bus.m_axis_tstrb !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b b=%b en=%b r=%b%b l=%b t=%b d=%h s=%h exp all 0",
                     bus.m_axis_tvalid, bus.busy, bus.mem_rd_en, bus.req1_ready, bus.req0_ready,
                     bus.m_axis_tlast, bus.m_axis_tdest, bus.m_axis_tdata, bus.m_axis_tstrb);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b tvalid=%b exp 0 0", bus.busy, bus.m_axis_tvalid);
        end
        @(posedge clk); #1;
    endtask

    // One isolated burst with tready high: exact cycle timing
    task automatic test_single(input logic ch, input logic [AW-1:0] base, input logic [LW-1:0] len);
        int n = int'(len) + 1;
        bus.m_axis_tready = 1'b1;
        if (ch) begin bus.req1_valid = 1'b1; bus.req1_base = base; bus.req1_len = len; end
        else    begin bus.req0_valid = 1'b1; bus.req0_base = base; bus.req0_len = len; end
        @(negedge clk);
        checks++;
        if ((ch ? bus.req1_ready : bus.req0_ready) !== 1'b1) begin
            errors++;
            $display("FAIL single_accept got 0 exp 1 (ch%0d)", ch);
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int k = 1; k <= n + 3; k++) begin
            logic          e_en, e_v;
            logic [AW-1:0] a;
            @(negedge clk);
            e_en = (k <= n);
            e_v  = (k >= 3) && (k <= n + 2);
            checks++;
            if (bus.mem_rd_en !== e_en) begin
                errors++;
                $display("FAIL single_en k=%0d got %b exp %b", k, bus.mem_rd_en, e_en);
            end
            a = base + AW'(k - 1);
            if (e_en) begin
                checks++;
                if (bus.mem_rd_addr !== a) begin
                    errors++;
                    $display("FAIL single_addr k=%0d got %h exp %h", k, bus.mem_rd_addr, a);
                end
            end
            checks++;
            if (bus.m_axis_tvalid !== e_v) begin
                errors++;
                $display("FAIL single_tvalid k=%0d got %b exp %b", k, bus.m_axis_tvalid, e_v);
            end
            if (e_v) begin
                a = base + AW'(k - 3);
                checks++;
                if (bus.m_axis_tdata !== mem_val(a) || bus.m_axis_tlast !== (k == n + 2) ||
                    bus.m_axis_tdest !== ch) begin
                    errors++;
                    $display("FAIL single_beat k=%0d got d=%h l=%b t=%b exp d=%h l=%b t=%b", k,
                             bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tdest,
                             mem_val(a), (k == n + 2), ch);
                end
            end
            checks++;
            if (bus.busy !== (k <= n + 2)) begin
                errors++;
                $display("FAIL single_busy k=%0d got %b exp %b", k, bus.busy, (k <= n + 2));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_arb();
        int got = 0;
        do_reset();
        bus.m_axis_tready = 1'b1;
        bus.req0_base = 12'h200; bus.req0_len = 8'd1;
        bus.req1_base = 12'h300; bus.req1_len = 8'd2;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int c = 0; c < 400 && got < 6; c++) begin
            @(negedge clk);
            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
                checks++;
                if (bus.req1_ready !== (got % 2 == 1)) begin
                    errors++;
                    $display("FAIL arb_order grant#%0d got ch%0d exp ch%0d", got, bus.req1_ready, got % 2);
                end
                got++;
            end
            @(posedge clk); #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        checks++;
        if (got != 6) begin
            errors++;
            $display("FAIL arb_timeout got %0d grants exp 6", got);
        end
        wait_done("arb");
    endtask

    task automatic test_backpressure();
        int p0 = pops;
        int seen = 0;
        bus.m_axis_tready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_base = 12'h040; bus.req0_len = 8'd7;
        @(negedge clk);
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk); #1;
            if (pops != p0) seen = 1;
            @(posedge clk); #1;
        end
        bus.m_axis_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (c == 4) begin
                checks++;
                if (bus.mem_rd_en !== 1'b0 || outstanding != 4) begin
                    errors++;
                    $display("FAIL bp_credit got en=%b occ=%0d exp en=0 occ=4", bus.mem_rd_en, outstanding);
                end
            end
            @(posedge clk); #1;
        end
        bus.m_axis_tready = 1'b1;
        wait_done("bp");
        checks++;
        if (pops - p0 != 8) begin
            errors++;
            $display("FAIL bp_beats got %0d exp 8", pops - p0);
        end
    endtask

    task automatic test_reset_mid();
        int i0 = issues;
        int p0;
        bus.m_axis_tready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_base = 12'h080; bus.req0_len = 8'd5;
        @(negedge clk);
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        for (int c = 0; c < 20 && issues - i0 < 3; c++) begin
            @(negedge clk); #1;
            if (issues - i0 < 3) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_axis_tvalid !== 1'b0 || bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL abort got v=%b busy=%b en=%b exp 0 0 0", bus.m_axis_tvalid, bus.busy, bus.mem_rd_en);
        end
        @(posedge clk); #1;
        p0 = pops;
        bus.m_axis_tready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_base = 12'h020; bus.req0_len = 8'd1;
        @(negedge clk);
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        wait_done("post_reset");
        checks++;
        if (pops - p0 != 2) begin
            errors++;
            $display("FAIL post_reset_beats got %0d exp 2", pops - p0);
        end
    endtask

    task automatic test_random();
        logic a0, a1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            @(posedge clk); #1;
            if (a0) bus.req0_valid = 1'b0;
            if (a1) bus.req1_valid = 1'b0;
            if (!bus.req0_valid && $urandom_range(0, 3) == 0) begin
                bus.req0_valid = 1'b1;
                bus.req0_base  = AW'($urandom);
                bus.req0_len   = LW'($urandom_range(0, 7));
            end
            if (!bus.req1_valid && $urandom_range(0, 3) == 0) begin
                bus.req1_valid = 1'b1;
                bus.req1_base  = AW'($urandom);
                bus.req1_len   = LW'($urandom_range(0, 7));
            end
            bus.m_axis_tready = ($urandom_range(0, 3) != 0);
        end
        bus.m_axis_tready = 1'b1;
        for (int c = 0; c < 200 && (bus.req0_valid || bus.req1_valid); c++) begin
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            @(posedge clk); #1;
            if (a0) bus.req0_valid = 1'b0;
            if (a1) bus.req1_valid = 1'b0;
        end
        checks++;
        if (bus.req0_valid || bus.req1_valid) begin
            errors++;
            $display("FAIL rand_accept got pending=%b%b exp 00", bus.req1_valid, bus.req0_valid);
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end
        wait_done("rand");
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_base = '0; bus.req0_len = '0;
        bus.req1_valid = 1'b0; bus.req1_base = '0; bus.req1_len = '0;
        bus.m_axis_tready = 1'b0;
        test_reset();
        test_single(1'b0, 12'h010, 8'd3);
        test_arb();
        test_backpressure();
        test_single(1'b1, 12'hFFE, 8'd3);
        test_reset_mid();
        test_single(1'b0, 12'h100, 8'd0);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
